count_day: RTL

- BCD day-of-month counter that sits directly upstream of the month counter.
- Advances on a one-cycle day-enable pulse from the hour stage.
- Wraps at the correct month length (28/29/30/31), using the current month digits and a leap flag fed back from the month and year stages.
- Emits pulse_d to drive the month stage's en_mo. Also supports manual up/down adjustment in set mode.

---
 rtl/count_day.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/count_day.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// count_day
//
// BCD day-of-month counter for the calendar chain. Sits between the hour stage
// (which supplies the one-cycle day-advance pulse en_d) and the month stage
// (which consumes pulse_d as its en_mo). The month length is derived from the
// month digits and the leap flag fed back from the month and year stages.
//
// Ports:
//   clk         in   system clock, all state updates on the rising edge
//   rst         in   synchronous reset, active-high; loads day 01
//   en_d        in   one-cycle day-advance pulse from the hour stage
//   adj         in   set mode: 1 = manual adjust, en_d ignored
//   up          in   one-cycle increment request (adj=1 only)
//   down        in   one-cycle decrement request (adj=1 only)
//   month_unit  in   current month units digit (BCD)
//   month_ten   in   current month tens digit (BCD)
//   leap        in   1 = current year is a leap year
//   day_unit    out  day units digit (BCD), registered
//   day_ten     out  day tens digit (BCD), registered
//   last_day    out  combinational: day equals the current month length
//   pulse_d     out  combinational: month-advance pulse to the month stage
// -----------------------------------------------------------------------------
module count_day #(
  parameter int MAX_DISPLAY_UNIT = 4,
  parameter int MAX_DISPLAY_TEN  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_d,
  input  logic                        adj,
  input  logic                        up,
  input  logic                        down,
  input  logic [3:0]                  month_unit,
  input  logic [1:0]                  month_ten,
  input  logic                        leap,
  output logic [MAX_DISPLAY_UNIT-1:0] day_unit,
  output logic [MAX_DISPLAY_TEN-1:0]  day_ten,
  output logic                        last_day,
  output logic                        pulse_d
);

  // Day value held as two BCD digits, exactly as displayed.
  logic [MAX_DISPLAY_UNIT-1:0] r_day_unit;
  logic [MAX_DISPLAY_TEN-1:0]  r_day_ten;

  // Binary view of the day. Six bits so that a corrupted digit pair
  // (e.g. 3 and 9) still reads as its true, out-of-range value and is
  // pulled back by the clamp rather than aliasing into the valid range.
  logic [5:0] w_day_bin;
  logic [5:0] w_day_inc;
  logic [5:0] w_day_dec;
  logic [5:0] w_days_max;
  logic       w_last_day;
  logic       w_clamp;
  logic [5:0] w_next_bin;
  logic [MAX_DISPLAY_UNIT-1:0] w_next_unit;
  logic [MAX_DISPLAY_TEN-1:0]  w_next_ten;
  logic [1:0] w_next_ten_raw;

  assign w_day_bin = 6'(r_day_ten) * 6'd10 + 6'(r_day_unit);
  assign w_day_inc = w_day_bin + 6'd1;
  assign w_day_dec = w_day_bin - 6'd1;

  // Month length. Anything that is not a valid month 01..12 falls through
  // to 31 so a glitched month input can never shorten the current month.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_days_max = 6'd31;
    case (month_ten)
      2'd0: begin
        case (month_unit)
          4'd2:                w_days_max = leap ? 6'd29 : 6'd28;
          4'd4, 4'd6, 4'd9:    w_days_max = 6'd30;
          default:             w_days_max = 6'd31;
        endcase
      end
      2'd1: begin
        if (month_unit == 4'd1) begin
          w_days_max = 6'd30;
        end
      end
      default: w_days_max = 6'd31;
    endcase
  end

  assign w_last_day = (w_day_bin == w_days_max);

  // Day beyond the month end, typically because the month stage just moved
  // to a shorter month while the day sat at 29..31.
  assign w_clamp = (w_day_bin > w_days_max);

  // Next-day selection, priority clamp > adjust > count > hold. Reset is
  // applied in the register process and overrides all of these.
  always_comb begin
    w_next_bin = w_day_bin;
    if (w_clamp) begin
      w_next_bin = w_days_max;
    end else if (adj) begin
      if (up && !down) begin
        w_next_bin = w_last_day ? 6'd1 : w_day_inc;
      end else if (down && !up) begin
        // A day of 00 (never produced, only seen after an upset) also
        // wraps to the month end, like 01.
        w_next_bin = (w_day_bin <= 6'd1) ? w_days_max : w_day_dec;
      end
    end else if (en_d) begin
      // A day of 00 simply increments to 01 here with no month carry.
      w_next_bin = w_last_day ? 6'd1 : w_day_inc;
    end
  end

  // Binary to BCD split. w_next_bin is always within 1..31 here.
  always_comb begin
    w_next_ten_raw = 2'd0;
    if (w_next_bin >= 6'd30) begin
      w_next_ten_raw = 2'd3;
    end else if (w_next_bin >= 6'd20) begin
      w_next_ten_raw = 2'd2;
    end else if (w_next_bin >= 6'd10) begin
      w_next_ten_raw = 2'd1;
    end
  end

  assign w_next_ten  = MAX_DISPLAY_TEN'(w_next_ten_raw);
  assign w_next_unit = MAX_DISPLAY_UNIT'(w_next_bin - 6'(w_next_ten_raw) * 6'd10);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_day_ten  <= '0;
      r_day_unit <= MAX_DISPLAY_UNIT'(1);
    end else begin
      r_day_ten  <= w_next_ten;
      r_day_unit <= w_next_unit;
    end
  end

  assign day_unit = r_day_unit;
  assign day_ten  = r_day_ten;
  assign last_day = w_last_day;

  // Zero-latency carry: high during the cycle whose edge wraps the day to
  // 01, so the month stage advances on that same edge. Adjust and clamp
  // never carry.
  assign pulse_d = en_d & ~adj & w_last_day & ~w_clamp & ~rst;

endmodule
